// File: rtl/dpsk_dac_tx.sv
`default_nettype none
// ============================================================================
//  Module   : dpsk_dac_tx
//  Purpose  : DPSK transmitter. Serial bits in over valid/ready. A '1' flips
//             the carrier phase by 180 degrees and a '0' keeps it. Samples
//             come from a 64-entry sine LUT and are emitted as 8-bit offset
//             binary at FS, together with a free-running DAC clock.
//  Revision : 1.0  initial release
// ============================================================================

`ifndef SYS_CLK_FREQ
`define SYS_CLK_FREQ 50_000_000
`endif
`ifndef FS
`define FS 1_000_000
`endif

module dpsk_dac_tx #(
  parameter int CLK_FREQ   = `SYS_CLK_FREQ,
  parameter int FS         = `FS,
  parameter int SPS        = 16,
  parameter int PHASE_STEP = 4
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       tx_bit,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic [7:0] dac_data,
  output logic       dac_data_valid,
  output logic       dac_clk
);

  localparam int              c_CNT_DIV  = CLK_FREQ / FS;
  localparam int              c_CW       = (c_CNT_DIV > 1) ? $clog2(c_CNT_DIV) : 1;
  localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(c_CNT_DIV - 1);
  localparam logic [c_CW-1:0] c_CNT_HALF = c_CW'(c_CNT_DIV / 2 - 1);
  localparam int              c_SW       = (SPS > 1) ? $clog2(SPS) : 1;
  localparam logic [c_SW-1:0] c_SYM_LAST = c_SW'(SPS - 1);
  localparam logic [5:0]      c_STEP     = 6'(PHASE_STEP);
  localparam logic [5:0]      c_FLIP     = 6'd32;
  localparam logic [7:0]      c_MID      = 8'h80;

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_RUN  = 1'b1;

  // 128 + round(127*sin(2*pi*i/64))
  function automatic logic [7:0] sine_lut(input logic [5:0] idx);
    logic [7:0] v;
    case (idx)
      6'd0:  v = 8'd128; 6'd1:  v = 8'd140; 6'd2:  v = 8'd153; 6'd3:  v = 8'd165;
      6'd4:  v = 8'd177; 6'd5:  v = 8'd188; 6'd6:  v = 8'd199; 6'd7:  v = 8'd209;
      6'd8:  v = 8'd218; 6'd9:  v = 8'd226; 6'd10: v = 8'd234; 6'd11: v = 8'd240;
      6'd12: v = 8'd245; 6'd13: v = 8'd250; 6'd14: v = 8'd253; 6'd15: v = 8'd254;
      6'd16: v = 8'd255; 6'd17: v = 8'd254; 6'd18: v = 8'd253; 6'd19: v = 8'd250;
      6'd20: v = 8'd245; 6'd21: v = 8'd240; 6'd22: v = 8'd234; 6'd23: v = 8'd226;
      6'd24: v = 8'd218; 6'd25: v = 8'd209; 6'd26: v = 8'd199; 6'd27: v = 8'd188;
      6'd28: v = 8'd177; 6'd29: v = 8'd165; 6'd30: v = 8'd153; 6'd31: v = 8'd140;
      6'd32: v = 8'd128; 6'd33: v = 8'd116; 6'd34: v = 8'd103; 6'd35: v = 8'd91;
      6'd36: v = 8'd79;  6'd37: v = 8'd68;  6'd38: v = 8'd57;  6'd39: v = 8'd47;
      6'd40: v = 8'd38;  6'd41: v = 8'd30;  6'd42: v = 8'd22;  6'd43: v = 8'd16;
      6'd44: v = 8'd11;  6'd45: v = 8'd6;   6'd46: v = 8'd3;   6'd47: v = 8'd2;
      6'd48: v = 8'd1;   6'd49: v = 8'd2;   6'd50: v = 8'd3;   6'd51: v = 8'd6;
      6'd52: v = 8'd11;  6'd53: v = 8'd16;  6'd54: v = 8'd22;  6'd55: v = 8'd30;
      6'd56: v = 8'd38;  6'd57: v = 8'd47;  6'd58: v = 8'd57;  6'd59: v = 8'd68;
      6'd60: v = 8'd79;  6'd61: v = 8'd91;  6'd62: v = 8'd103; 6'd63: v = 8'd116;
      default: v = 8'd128;
    endcase
    return v;
  endfunction

  logic [c_CW-1:0] cnt_div_q, cnt_div_d;
  logic            dac_clk_q, dac_clk_d;
  logic [7:0]      dac_data_q, dac_data_d;
  logic            dac_valid_q, dac_valid_d;
  logic            buf_full_q, buf_full_d;
  logic            buf_bit_q, buf_bit_d;
  logic [5:0]      phase_acc_q, phase_acc_d;
  logic [5:0]      phase_off_q, phase_off_d;
  logic [c_SW-1:0] sym_cnt_q, sym_cnt_d;
  logic [0:0]      state_q, state_d;

  logic       w_samp_stb;
  logic       w_need;
  logic [5:0] w_off_new;
  logic [5:0] w_idx_new;
  logic [5:0] w_idx_run;

  assign w_samp_stb = (cnt_div_q == c_CNT_LAST);
  assign w_need     = (state_q == c_IDLE) || (sym_cnt_q == c_SYM_LAST);
  // The new symbol's offset is applied to its very first sample.
  assign w_off_new  = phase_off_q ^ (buf_bit_q ? c_FLIP : 6'd0);
  assign w_idx_new  = phase_acc_q + w_off_new;
  assign w_idx_run  = phase_acc_q + phase_off_q;

  assign tx_ready       = !buf_full_q;
  assign tx_busy        = (state_q == c_RUN);
  assign dac_data       = dac_data_q;
  assign dac_data_valid = dac_valid_q;
  assign dac_clk        = dac_clk_q;

  // Next-state logic: divider, DAC clock, input buffer and symbol sequencer.
  always_comb begin
    cnt_div_d   = w_samp_stb ? '0 : cnt_div_q + 1'b1;
    dac_clk_d   = dac_clk_q;
    dac_data_d  = dac_data_q;
    dac_valid_d = w_samp_stb;
    buf_full_d  = buf_full_q;
    buf_bit_d   = buf_bit_q;
    phase_acc_d = phase_acc_q;
    phase_off_d = phase_off_q;
    sym_cnt_d   = sym_cnt_q;
    state_d     = state_q;

    if (w_samp_stb)
      dac_clk_d = 1'b0;
    else if (cnt_div_q == c_CNT_HALF)
      dac_clk_d = 1'b1;

    if (tx_valid && !buf_full_q) begin
      buf_full_d = 1'b1;
      buf_bit_d  = tx_bit;
    end

    if (w_samp_stb) begin
      if (w_need && buf_full_q) begin
        buf_full_d  = 1'b0;
        phase_off_d = w_off_new;
        dac_data_d  = sine_lut(w_idx_new);
        phase_acc_d = phase_acc_q + c_STEP;
        sym_cnt_d   = '0;
        state_d     = c_RUN;
      end else if (w_need) begin
        // Underrun or end of burst: park at midscale, next burst restarts at phase 0.
        dac_data_d  = c_MID;
        phase_acc_d = '0;
        phase_off_d = '0;
        sym_cnt_d   = '0;
        state_d     = c_IDLE;
      end else begin
        dac_data_d  = sine_lut(w_idx_run);
        phase_acc_d = phase_acc_q + c_STEP;
        sym_cnt_d   = sym_cnt_q + 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      cnt_div_q   <= '0;
      dac_clk_q   <= 1'b0;
      dac_data_q  <= c_MID;
      dac_valid_q <= 1'b0;
      buf_full_q  <= 1'b0;
      buf_bit_q   <= 1'b0;
      phase_acc_q <= '0;
      phase_off_q <= '0;
      sym_cnt_q   <= '0;
      state_q     <= c_IDLE;
    end else begin
      cnt_div_q   <= cnt_div_d;
      dac_clk_q   <= dac_clk_d;
      dac_data_q  <= dac_data_d;
      dac_valid_q <= dac_valid_d;
      buf_full_q  <= buf_full_d;
      buf_bit_q   <= buf_bit_d;
      phase_acc_q <= phase_acc_d;
      phase_off_q <= phase_off_d;
      sym_cnt_q   <= sym_cnt_d;
      state_q     <= state_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dpsk_dac_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dpsk_dac_tx
//  Purpose  : Directed self-checking bench for dpsk_dac_tx (CNT_DIV = 50,
//             SPS = 16, PHASE_STEP = 4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_dpsk_dac_tx;

  localparam int CNT_DIV = 50;
  localparam int SPS     = 16;

  logic       sys_clk = 1'b0;
  logic       rst     = 1'b1;
  logic       tx_bit  = 1'b0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx_busy;
  logic [7:0] dac_data;
  logic       dac_data_valid;
  logic       dac_clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Samples at phase index 4*k (hand-computed 128+round(127*sin)).
  logic [7:0] lut16 [16] = '{8'd128, 8'd177, 8'd218, 8'd245, 8'd255, 8'd245, 8'd218, 8'd177,
                             8'd128, 8'd79,  8'd38,  8'd11,  8'd1,   8'd11,  8'd38,  8'd79};

  dpsk_dac_tx #(
    .CLK_FREQ  (50_000_000),
    .FS        (1_000_000),
    .SPS       (SPS),
    .PHASE_STEP(4)
  ) dut (
    .sys_clk       (sys_clk),
    .rst           (rst),
    .tx_bit        (tx_bit),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .tx_busy       (tx_busy),
    .dac_data      (dac_data),
    .dac_data_valid(dac_data_valid),
    .dac_clk       (dac_clk)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // Offer one bit; returns the cycle stamp of the handshake edge.
  task automatic send_bit(input logic b, input bit hold, output int hs_cyc);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    tx_bit = b;
    tx_valid = 1'b1;
    while (!acc && n < 2000) begin
      acc = tx_ready;
      tick();
      n++;
    end
    hs_cyc = cyc;
    if (!hold) tx_valid = 1'b0;
    chk("handshake", int'(acc), 1);
    chk("ready_low_after_push", int'(tx_ready), 0);
  endtask

  // Advance to the next dac_data_valid pulse and return the sample.
  task automatic get_sample(output logic [7:0] d);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!dac_data_valid && n < 2 * CNT_DIV);
    if (!dac_data_valid) chk("sample_timeout", int'(dac_data_valid), 1);
    d = dac_data;
  endtask

  function automatic logic [7:0] exp_samp(input bit flipped, input int k);
    return lut16[(k + (flipped ? 8 : 0)) % 16];
  endfunction

  logic [7:0] samp [0:127];
  logic       bits [0:7];

  initial begin
    logic [7:0] d;
    int hs, t0, n, hi, lo;
    int hs_t [0:7];
    bit off;

    // ---------------- Test 1: reset and idle ----------------
    tick(); tick(); tick();
    chk("rst_dac_data", dac_data, 8'h80);
    chk("rst_valid", dac_data_valid, 0);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_dac_clk", dac_clk, 0);
    rst = 1'b0;

    n = 0;
    while (dac_clk !== 1'b1 && n < 200) begin tick(); n++; end
    hi = 0;
    while (dac_clk === 1'b1 && hi < 200) begin tick(); hi++; end
    chk("t1_valid_at_fall", dac_data_valid, 1);
    lo = 0;
    while (dac_clk === 1'b0 && lo < 200) begin tick(); lo++; end
    chk("t1_clk_high_cycles", hi, CNT_DIV / 2);
    chk("t1_clk_low_cycles", lo, CNT_DIV / 2);

    get_sample(d); t0 = cyc;
    chk("t1_idle_sample0", d, 8'h80);
    get_sample(d);
    chk("t1_idle_sample1", d, 8'h80);
    chk("t1_valid_period", cyc - t0, CNT_DIV);
    tick();
    chk("t1_valid_one_cycle", dac_data_valid, 0);
    chk("t1_idle_ready", tx_ready, 1);
    chk("t1_idle_busy", tx_busy, 0);

    // ---------------- Test 2: single bit 0 ----------------
    send_bit(1'b0, 1'b0, hs);
    for (int k = 0; k < SPS; k++) begin
      get_sample(d);
      chk($sformatf("t2_samp%0d", k), d, exp_samp(1'b0, k));
      chk($sformatf("t2_busy%0d", k), tx_busy, 1);
      if (k == 0) chk("t2_ready_after_pop", tx_ready, 1);
    end
    get_sample(d);
    chk("t2_tail_mid", d, 8'h80);
    chk("t2_tail_busy", tx_busy, 0);

    // ---------------- Test 3: bits 1,1,0 back-to-back ----------------
    bits[0] = 1'b1; bits[1] = 1'b1; bits[2] = 1'b0;
    send_bit(bits[0], 1'b0, hs);
    fork
      begin
        int h;
        send_bit(bits[1], 1'b0, h);
        send_bit(bits[2], 1'b0, h);
      end
      begin
        for (int i = 0; i < 3 * SPS + 1; i++) get_sample(samp[i]);
      end
    join
    off = 1'b0;
    for (int s = 0; s < 3; s++) begin
      off = off ^ bits[s];
      for (int k = 0; k < SPS; k++)
        chk($sformatf("t3_sym%0d_samp%0d", s, k), samp[s * SPS + k], exp_samp(off, k));
    end
    chk("t3_tail_mid", samp[3 * SPS], 8'h80);

    // ---------------- Test 4: tx_valid held high, random bits ----------------
    for (int i = 0; i < 6; i++) bits[i] = 1'($urandom_range(0, 1));
    send_bit(bits[0], 1'b1, hs_t[0]);
    fork
      begin
        for (int i = 1; i < 6; i++) send_bit(bits[i], 1'b1, hs_t[i]);
        tx_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 6 * SPS + 1; i++) get_sample(samp[i]);
      end
    join
    for (int i = 2; i < 6; i++)
      chk($sformatf("t4_hs_spacing%0d", i), hs_t[i] - hs_t[i - 1], SPS * CNT_DIV);
    off = 1'b0;
    for (int s = 0; s < 6; s++) begin
      off = off ^ bits[s];
      for (int k = 0; k < SPS; k++)
        chk($sformatf("t4_sym%0d_samp%0d", s, k), samp[s * SPS + k], exp_samp(off, k));
    end
    chk("t4_tail_mid", samp[6 * SPS], 8'h80);

    // ---------------- Test 5: underrun then resume ----------------
    send_bit(1'b0, 1'b0, hs);
    for (int k = 0; k < SPS; k++) begin
      get_sample(d);
      chk($sformatf("t5_samp%0d", k), d, exp_samp(1'b0, k));
    end
    for (int k = 0; k < 3; k++) begin
      get_sample(d);
      chk($sformatf("t5_idle%0d", k), d, 8'h80);
    end
    send_bit(1'b1, 1'b0, hs);
    get_sample(d);
    chk("t5_resume0", d, 8'd128);
    get_sample(d);
    chk("t5_resume1", d, 8'd79);
    for (int k = 2; k < SPS + 1; k++) get_sample(d);
    chk("t5_tail_mid", d, 8'h80);

    // ---------------- Test 6: reset mid-symbol with a bit buffered ----------------
    send_bit(1'b0, 1'b0, hs);
    get_sample(d);
    chk("t6_samp0", d, 8'd128);
    send_bit(1'b1, 1'b0, hs);
    for (int k = 1; k < 7; k++) get_sample(d);
    chk("t6_samp6", d, exp_samp(1'b0, 6));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_data", dac_data, 8'h80);
    chk("t6_rst_dac_clk", dac_clk, 0);
    chk("t6_rst_ready", tx_ready, 1);
    chk("t6_rst_busy", tx_busy, 0);
    chk("t6_rst_valid", dac_data_valid, 0);
    for (int k = 0; k < 2 * SPS; k++) begin
      get_sample(d);
      chk($sformatf("t6_after_rst%0d", k), d, 8'h80);
    end
    chk("t6_after_rst_busy", tx_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
